// File: rtl/sonar_section_scheduler_if.sv
// Command-FIFO heads and AXI-Stream output shared between the section scheduler and its environment.
interface sonar_section_scheduler_if #(
  parameter int N_SEC  = 4,
  parameter int DATA_W = 32
);
  localparam int TID_W = $clog2(N_SEC);

  logic [N_SEC-1:0]        sec_valid;
  logic [3*N_SEC-1:0]      sec_op;
  logic [DATA_W*N_SEC-1:0] sec_arg;
  logic [N_SEC-1:0]        sec_ready;
  logic [DATA_W-1:0]       m_axis_tdata;
  logic [TID_W-1:0]        m_axis_tid;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    input  sec_valid, sec_op, sec_arg, m_axis_tready,
    output sec_ready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

  modport slave (
    output sec_valid, sec_op, sec_arg, m_axis_tready,
    input  sec_ready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );
endinterface

// File: rtl/sonar_section_scheduler.sv
// Parallel-section command scheduler with round-robin stream arbitration, flag sync and vector barrier.
// Optional watchdog enabled by defining SONAR_SCHED_TIMEOUT_EN.
module sonar_section_scheduler #(
  parameter int N_SEC          = 4,
  parameter int DATA_W         = 32,
  parameter int FLAG_COUNT     = 8,
  parameter int DELAY_W        = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_SEC-1:0]          sec_active,
  sonar_section_scheduler_if.master bus,
  output logic [FLAG_COUNT-1:0]     flags,
  output logic                      vector_done,
  output logic [15:0]               vector_count,
  output logic                      error,
  output logic                      timeout
);
  localparam int TID_W  = $clog2(N_SEC);
  localparam int FLAG_W = $clog2(FLAG_COUNT);

  localparam logic [2:0] OP_DRIVE = 3'd0;
  localparam logic [2:0] OP_FSET  = 3'd1;
  localparam logic [2:0] OP_FCLR  = 3'd2;
  localparam logic [2:0] OP_WAIT  = 3'd3;
  localparam logic [2:0] OP_DELAY = 3'd4;
  localparam logic [2:0] OP_END   = 3'd5;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_e;
  typedef enum logic [1:0] {S_ACTIVE, S_DELAYING, S_WAITING, S_ENDED} sec_e;

  top_e                  top_q, top_d;
  sec_e                  sec_q   [N_SEC];
  sec_e                  sec_d   [N_SEC];
  logic [DELAY_W-1:0]    dly_q   [N_SEC];
  logic [DELAY_W-1:0]    dly_d   [N_SEC];
  logic [FLAG_W-1:0]     widx_q  [N_SEC];
  logic [FLAG_W-1:0]     widx_d  [N_SEC];
  logic [TID_W-1:0]      rr_q, rr_d;
  logic [FLAG_COUNT-1:0] flags_q, flags_d;
  logic [DATA_W-1:0]     tdata_q, tdata_d;
  logic [TID_W-1:0]      tid_q, tid_d;
  logic                  tvalid_q, tvalid_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [2:0]            op  [N_SEC];
  logic [DATA_W-1:0]     arg [N_SEC];
  logic [N_SEC-1:0]      cmd_ok, drv_req, ready;
  logic                  can_load, found, gnt_fire;
  logic [TID_W-1:0]      gnt;
  logic [FLAG_COUNT-1:0] set_m, clr_m;
  logic                  all_ended;

  // Command decode and round-robin grant; a grant only fires when the output register can load.
  always_comb begin
    for (int i = 0; i < N_SEC; i++) begin
      op[i]      = bus.sec_op[3*i +: 3];
      arg[i]     = bus.sec_arg[DATA_W*i +: DATA_W];
      cmd_ok[i]  = (top_q == T_RUN) && (sec_q[i] == S_ACTIVE) && bus.sec_valid[i];
      drv_req[i] = cmd_ok[i] && (op[i] == OP_DRIVE);
    end
    can_load = !tvalid_q || bus.m_axis_tready;
    found    = 1'b0;
    gnt      = '0;
    for (int k = 0; k < N_SEC; k++) begin
      if (!found && drv_req[(int'(rr_q) + k) % N_SEC]) begin
        found = 1'b1;
        gnt   = TID_W'((int'(rr_q) + k) % N_SEC);
      end
    end
    gnt_fire = found && can_load;
    for (int i = 0; i < N_SEC; i++)
      ready[i] = cmd_ok[i] && ((op[i] != OP_DRIVE) || (gnt_fire && (int'(gnt) == i)));
  end

`ifdef SONAR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_fire, timeout_q, timeout_d;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((top_q == T_RUN) && !(|ready) && !(tvalid_q && bus.m_axis_tready)) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) wd_fire = 1'b1;
      else                                   wd_d    = wd_q + 1'b1;
    end
  end
`endif

  always_comb begin
    top_d     = top_q;
    rr_d      = rr_q;
    tdata_d   = tdata_q;
    tid_d     = tid_q;
    tvalid_d  = tvalid_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    set_m     = '0;
    clr_m     = '0;
    all_ended = 1'b1;
    for (int i = 0; i < N_SEC; i++) begin
      sec_d[i]  = sec_q[i];
      dly_d[i]  = dly_q[i];
      widx_d[i] = widx_q[i];
      if (sec_q[i] != S_ENDED) all_ended = 1'b0;
      case (sec_q[i])
        S_DELAYING: begin
          if (dly_q[i] <= DELAY_W'(1)) sec_d[i] = S_ACTIVE;
          else                         dly_d[i] = dly_q[i] - 1'b1;
        end
        S_WAITING: if (flags_q[widx_q[i]]) sec_d[i] = S_ACTIVE;
        default: ;
      endcase
      if (ready[i]) begin
        case (op[i])
          OP_DRIVE: ;
          OP_FSET: begin
            if (arg[i] < DATA_W'(FLAG_COUNT)) set_m[arg[i][FLAG_W-1:0]] = 1'b1;
            else                              err_d = 1'b1;
          end
          OP_FCLR: begin
            if (arg[i] < DATA_W'(FLAG_COUNT)) clr_m[arg[i][FLAG_W-1:0]] = 1'b1;
            else                              err_d = 1'b1;
          end
          OP_WAIT: begin
            if (arg[i] < DATA_W'(FLAG_COUNT)) begin
              sec_d[i]  = S_WAITING;
              widx_d[i] = arg[i][FLAG_W-1:0];
            end else begin
              err_d = 1'b1;
            end
          end
          OP_DELAY: begin
            if (arg[i][DELAY_W-1:0] != '0) begin
              sec_d[i] = S_DELAYING;
              dly_d[i] = arg[i][DELAY_W-1:0];
            end
          end
          OP_END:  sec_d[i] = S_ENDED;
          default: err_d = 1'b1;
        endcase
      end
    end
    flags_d = (flags_q & ~clr_m) | set_m;

    if (gnt_fire) begin
      tdata_d  = arg[gnt];
      tid_d    = gnt;
      tvalid_d = 1'b1;
      rr_d     = TID_W'((int'(gnt) + 1) % N_SEC);
    end else if (bus.m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (top_q)
      T_IDLE: begin
        if (start) begin
          top_d = T_RUN;
          for (int i = 0; i < N_SEC; i++) sec_d[i] = sec_active[i] ? S_ACTIVE : S_ENDED;
        end
      end
      T_RUN:   if (all_ended && !tvalid_q) top_d = T_DONE;
      T_DONE: begin
        top_d = T_IDLE;
        cnt_d = cnt_q + 16'd1;
      end
      default: top_d = T_IDLE;
    endcase

`ifdef SONAR_SCHED_TIMEOUT_EN
    timeout_d = 1'b0;
    if (wd_fire) begin
      timeout_d = 1'b1;
      err_d     = 1'b1;
      tvalid_d  = 1'b0;
      for (int i = 0; i < N_SEC; i++) sec_d[i] = S_ENDED;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q    <= T_IDLE;
      rr_q     <= '0;
      flags_q  <= '0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < N_SEC; i++) begin
        sec_q[i]  <= S_ENDED;
        dly_q[i]  <= '0;
        widx_q[i] <= '0;
      end
    end else begin
      top_q    <= top_d;
      rr_q     <= rr_d;
      flags_q  <= flags_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tvalid_q <= tvalid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      for (int i = 0; i < N_SEC; i++) begin
        sec_q[i]  <= sec_d[i];
        dly_q[i]  <= dly_d[i];
        widx_q[i] <= widx_d[i];
      end
    end
  end

`ifdef SONAR_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  // Watchdog not built; the comparison is constant false for any legal limit.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign bus.sec_ready     = ready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign flags             = flags_q;
  assign vector_done       = (top_q == T_DONE);
  assign vector_count      = cnt_q;
  assign error             = err_q;
endmodule

// File: doc/sonar_section_scheduler.md
Name: sonar_section_scheduler

Overview:
- Synthesizable scheduler for one test vector's parallel command sections; commands come from per-section command FIFOs.
- Shares one AXI-Stream master driver between sections using round-robin arbitration.
- Executes flag set/clear/wait synchronisation and cycle delays.
- Raises a per-vector barrier when all participating sections reach END, then pulses completion and keeps a sticky error.

Parameters:
- N_SEC, 4, number of parallel sections (≥2).
- DATA_W, 32, stream data and argument width.
- FLAG_COUNT, 8, number of shared flags (≥2; FLAG_W = $clog2(FLAG_COUNT)).
- DELAY_W, 16, delay counter width.
- TIMEOUT_CYCLES, 65535, watchdog limit (optional feature only).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a vector; sampled only in IDLE.
- sec_active  in  N_SEC  participating sections; latched on accepted start.
- sec_valid  in  N_SEC  command present per section.
- sec_op  in  3*N_SEC  opcode per section.
- sec_arg  in  DATA_W*N_SEC  argument per section.
- sec_ready  out  N_SEC  command consumed this cycle (combinational).
- m_axis_tdata  out  DATA_W  driven word.
- m_axis_tid  out  $clog2(N_SEC)  source section.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  sink ready.
- flags  out  FLAG_COUNT  shared flag register.
- vector_done  out  1  one-cycle pulse at barrier.
- vector_count  out  16  completed vectors.
- error  out  1  sticky error.
- timeout  out  1  watchdog pulse.

Behaviour:
- Reset (asynchronous): every output is 0; top state IDLE; round-robin pointer 0; every section state ENDED.
- Opcodes:
  - 0 DRIVE
  - 1 FLAG_SET
  - 2 FLAG_CLR
  - 3 WAIT_SET
  - 4 DELAY
  - 5 END
  - 6/7 illegal: consumed, error<=1.
- Top FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE -> RUN: on start. Latch sec_active. Each active section goes ACTIVE; each inactive section goes ENDED.
  - RUN -> DONE: when all sections are ENDED and m_axis_tvalid=0.
  - DONE: lasts 1 cycle. vector_done=1, vector_count+1 (wraps at 2^16), then IDLE.
  - start in RUN/DONE is ignored. start with sec_active=0 reaches DONE 1 cycle after RUN entry.
- Section FSM: ACTIVE, DELAYING, WAITING, ENDED. sec_ready[i] is only ever 1 while section i is ACTIVE.
- DRIVE:
  - Arbitration is round-robin among ACTIVE sections with a valid DRIVE. Search starts at the pointer; the pointer then moves to grant+1 mod N_SEC.
  - A grant is issued only when the output register can load (!tvalid || tready).
  - The granted section sees sec_ready=1. tdata/tid/tvalid update on the next edge, so latency is 1 cycle.
  - Sustained throughput is 1 word per cycle.
  - tdata/tid stay stable while tvalid && !tready.
- FLAG_SET/FLAG_CLR:
  - Consumed the same cycle without arbitration.
  - Flag index is arg[FLAG_W-1:0]. If arg ≥ FLAG_COUNT, the command is consumed, error<=1, and no flag changes.
  - Simultaneous set and clear of the same flag: set wins.
  - The flag update is visible on flags the next cycle.
- WAIT_SET:
  - Consumed; section goes to WAITING.
  - Returns to ACTIVE in the cycle after flags[idx]=1 is observed.
  - If the flag is already set, WAITING lasts 1 cycle.
- DELAY:
  - arg[DELAY_W-1:0]=0: no stall.
  - Otherwise the section goes to DELAYING for exactly arg cycles, then ACTIVE.
- END: consumed; section goes to ENDED.
- Flags persist across vectors; they are cleared only by reset.
- Error persists until reset.

Optional Feature:
- Macro: SONAR_SCHED_TIMEOUT_EN.
- Defined:
  - Watchdog counts RUN cycles with no command consumed and no output handshake.
  - On reaching TIMEOUT_CYCLES: timeout pulses 1 cycle, error<=1, all sections are forced to ENDED, and the pending output word is dropped (tvalid<=0).
  - The FSM then reaches DONE normally.
- Undefined: no counter is built; timeout is tied to 0.

Test Plan:
- Reset: assert rst mid-RUN with tvalid=1 -> all outputs 0 asynchronously; after release, IDLE; start works.
- Arbitration:
  - Setup: sections 0–3 each issue DRIVE 0xA0+i then END, with tready=1.
  - Required output: tid order 0,1,2,3, tdata 0xA0..0xA3.
  - Then: vector_done pulses once and vector_count=1.
- Backpressure: tready=0 for 5 cycles with 2 sections driving -> tdata/tid held stable, no words lost, 2 words out in order after release.
- Synchronisation:
  - Setup: section 1 issues WAIT_SET 3 then DRIVE 0x55; section 0 issues DELAY 10 then FLAG_SET 3.
  - Required: 0x55 never appears before flags[3]=1; it appears ≥12 cycles after start.
- Errors: section 2 issues opcode 7, then FLAG_SET 9 with FLAG_COUNT=8 -> error=1 and stays 1; flags unchanged.
- Watchdog: with SONAR_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, section 0 waits on a flag that is never set -> timeout pulse at cycle 20, error=1, vector_done on the following cycles.
